// File: rtl/host_launcher.sv
// Host-side run launcher: preload data memory from a byte stream, reset and launch the core, wait for done, stream back a result window.
// Latency: first write one cycle after start; first out_valid two cycles after dut_done; readback 1 byte/cycle.
// Backpressure: in_valid low stalls LOAD; out_ready low holds out_data/out_valid stable. Optional watchdog: define HOST_TIMEOUT_EN.
module host_launcher #(
    parameter int AW        = 8,
    parameter int LOAD_BASE = 0,
    parameter int LOAD_LEN  = 64,
    parameter int READ_BASE = 64,
    parameter int READ_LEN  = 64,
    parameter int TIMEOUT   = 4096,
    parameter int RST_CYC   = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [7:0]    in_data,
    input  logic          in_valid,
    output logic          in_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wr_data,
    input  logic [7:0]    mem_rd_data,
    output logic          dut_reset,
    output logic          dut_req,
    input  logic          dut_done,
    output logic [7:0]    out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          busy,
    output logic          timed_out
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LOAD   = 3'd1;
    localparam logic [2:0] S_LAUNCH = 3'd2;
    localparam logic [2:0] S_RUN    = 3'd3;
    localparam logic [2:0] S_READ   = 3'd4;

    localparam int LW = $clog2(RST_CYC + 1);

    localparam logic [AW-1:0] LOAD_BASE_A = AW'(LOAD_BASE);
    localparam logic [AW-1:0] READ_BASE_A = AW'(READ_BASE);
    localparam logic [AW:0]   LOAD_LAST   = (AW+1)'(LOAD_LEN - 1);
    localparam logic [AW:0]   READ_LAST   = (AW+1)'(READ_LEN - 1);
    localparam logic [LW-1:0] RST_LAST    = LW'(RST_CYC);

    logic [2:0]    state_q, state_d;
    logic [AW:0]   idx_q, idx_d;
    logic [LW-1:0] lcnt_q, lcnt_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;

`ifdef HOST_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_MAX  = TW'(TIMEOUT);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

    logic [TW-1:0] run_cnt_q, run_cnt_d;
    logic          timed_out_q, timed_out_d;
`endif

    // Next-state, index, launch counter, readback register and watchdog.
    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        lcnt_d      = lcnt_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
`ifdef HOST_TIMEOUT_EN
        run_cnt_d   = run_cnt_q;
        timed_out_d = timed_out_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (start) begin
`ifdef HOST_TIMEOUT_EN
                    timed_out_d = 1'b0;
`endif
                    idx_d   = '0;
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                if (in_valid) begin
                    if (idx_q == LOAD_LAST) begin
                        idx_d   = '0;
                        lcnt_d  = '0;
                        state_d = S_LAUNCH;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_LAUNCH: begin
                // Counts RST_CYC reset cycles, then one request cycle.
                if (lcnt_q == RST_LAST) begin
                    state_d = S_RUN;
`ifdef HOST_TIMEOUT_EN
                    run_cnt_d = '0;
`endif
                end else begin
                    lcnt_d = lcnt_q + 1'b1;
                end
            end
            S_RUN: begin
                if (dut_done) begin
                    idx_d   = '0;
                    state_d = S_READ;
                end
`ifdef HOST_TIMEOUT_EN
                // Done has priority over an expiry in the same cycle.
                else if (run_cnt_q == TO_LAST) begin
                    timed_out_d = 1'b1;
                    state_d     = S_IDLE;
                end else if (run_cnt_q != TO_MAX) begin
                    run_cnt_d = run_cnt_q + 1'b1;
                end
`endif
            end
            S_READ: begin
                if (!out_valid_q) begin
                    out_data_d  = mem_rd_data;
                    out_valid_d = 1'b1;
                end else if (out_ready) begin
                    if (idx_q == READ_LAST) begin
                        out_valid_d = 1'b0;
                        idx_d       = '0;
                        state_d     = S_IDLE;
                    end else begin
                        // mem_addr already points one past the held byte.
                        out_data_d = mem_rd_data;
                        idx_d      = idx_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            lcnt_q      <= '0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
`ifdef HOST_TIMEOUT_EN
            run_cnt_q   <= '0;
            timed_out_q <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            lcnt_q      <= lcnt_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
`ifdef HOST_TIMEOUT_EN
            run_cnt_q   <= run_cnt_d;
            timed_out_q <= timed_out_d;
`endif
        end
    end

    // Memory port and core control decoded from state.
    always_comb begin
        in_ready    = (state_q == S_LOAD);
        mem_wr_en   = (state_q == S_LOAD) && in_valid;
        mem_wr_data = mem_wr_en ? in_data : 8'h00;
        mem_addr    = '0;
        if (state_q == S_LOAD) begin
            mem_addr = LOAD_BASE_A + idx_q[AW-1:0];
        end else if (state_q == S_READ) begin
            // While a byte is held, look ahead to the next one so a
            // handshake can capture it on the same edge.
            mem_addr = READ_BASE_A + idx_q[AW-1:0] + AW'(out_valid_q);
        end
        dut_reset = (state_q == S_IDLE) || ((state_q == S_LAUNCH) && (lcnt_q != RST_LAST));
        dut_req   = (state_q == S_LAUNCH) && (lcnt_q == RST_LAST);
        busy      = (state_q != S_IDLE);
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

`ifdef HOST_TIMEOUT_EN
    assign timed_out = timed_out_q;
`else
    assign timed_out = 1'b0;
`endif

endmodule

// File: doc/host_launcher.md
# host_launcher

Host-side initiator for the processor's `req`/`done` run handshake, sitting between the testbench/host stream and the core's data memory and control pins. It preloads a block of data memory from an input byte stream, resets and launches the core, waits for `done` with an optional watchdog, then streams back a result window of data memory. It is the other end of the core's start/finish protocol and takes over host access to `dat_mem` while the core is idle.

## Interface
- `AW`, 8: data-memory address width.
- `LOAD_BASE`, 0: first address written during preload.
- `LOAD_LEN`, 64: bytes preloaded (1..2^AW).
- `READ_BASE`, 64: first address read back.
- `READ_LEN`, 64: bytes read back (1..2^AW).
- `TIMEOUT`, 4096: maximum cycles in RUN before abort (used only with `HOST_TIMEOUT_EN`).
- `RST_CYC`, 2: cycles `dut_reset` is held during launch (≥1).

- `clk`  in  1  system clock; all logic on its rising edge.
- `reset`  in  1  synchronous, active-high.
- `start`  in  1  begin a job; sampled only in IDLE.
- `in_data`  in  8  preload byte.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  block accepts `in_data` this cycle.
- `mem_wr_en`  out  1  data-memory write strobe.
- `mem_addr`  out  AW  data-memory address.
- `mem_wr_data`  out  8  data-memory write data.
- `mem_rd_data`  in  8  data-memory read data, combinational from `mem_addr`.
- `dut_reset`  out  1  core reset.
- `dut_req`  out  1  core request pulse.
- `dut_done`  in  1  core done level.
- `out_data`  out  8  readback byte.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  consumer accepts `out_data`.
- `busy`  out  1  high in any state except IDLE.
- `timed_out`  out  1  sticky; last job aborted by the watchdog.

## Operation
- States: IDLE → LOAD → LAUNCH → RUN → READ → IDLE. RUN goes to IDLE on timeout.
- IDLE: `start`=1 clears `timed_out` and the index counter, then moves to LOAD.
- LOAD: `in_ready`=1. Each cycle with `in_valid`=1 gives `mem_wr_en`=1, `mem_addr`=`LOAD_BASE`+idx (mod 2^AW, wraps), and `mem_wr_data`=`in_data`, then idx++. After `LOAD_LEN` accepted bytes, idx clears and the block moves to LAUNCH. `in_valid`=0 stalls without penalty.
- LAUNCH: `dut_reset`=1 for `RST_CYC` cycles, then `dut_req`=1 for exactly 1 cycle, then RUN.
- RUN: `dut_done` is sampled every cycle. `dut_done`=1 moves to READ on the next edge. A `dut_done` seen in LOAD or LAUNCH is ignored.
- READ: `mem_addr`=`READ_BASE`+idx (wraps). The byte is captured into the `out_data` register and `out_valid` is raised. idx advances only on `out_valid`&&`out_ready`. After the `READ_LEN`-th transfer the block returns to IDLE.
- `mem_addr` is 0 and `mem_wr_en` is 0 outside LOAD/READ.
- `start` outside IDLE is ignored.

## Timing
- Reset values: state=IDLE, `in_ready`=0, `mem_wr_en`=0, `mem_addr`=0, `mem_wr_data`=0, `dut_reset`=1, `dut_req`=0, `out_data`=0, `out_valid`=0, `busy`=0, `timed_out`=0, idx=0.
- `dut_reset` is 1 in IDLE, so the core is held in reset while idle. It is 0 in LOAD and RUN.
- Cycle 0 = the `start` edge. With an always-valid input, the first write is in cycle 1 and the last in cycle `LOAD_LEN`. `dut_reset` is high in cycles `LOAD_LEN`+1 .. `LOAD_LEN`+`RST_CYC`, and `dut_req` is high in the following cycle.
- `dut_done` to the first `out_valid`: 2 cycles (RUN→READ edge, then the capture edge).
- Readback throughput is 1 byte/cycle with `out_ready` held high. `out_data` is stable while `out_valid` && !`out_ready`.
- `reset` mid-job: the job is abandoned immediately and all outputs take their reset values on the next edge. Memory contents are not restored.

## Configuration
- `HOST_TIMEOUT_EN` defined: a RUN-cycle counter saturates at `TIMEOUT`. When RUN has lasted `TIMEOUT` cycles without `dut_done`, `timed_out` is set (sticky) and the block goes to IDLE, skipping READ. If `dut_done` arrives in the same cycle as expiry, done wins.
- Not defined: no counter is built, RUN waits indefinitely, and `timed_out` is tied to 0.

## Test plan
- LOAD_LEN=4, LOAD_BASE=0x10, bytes A1,B2,C3,D4 with `in_valid` gaps → writes to 0x10..0x13 with exactly those values. Four `mem_wr_en` pulses total, and none during the gaps.
- After preload: `dut_reset` high for exactly `RST_CYC`=2 cycles, then a single-cycle `dut_req`. A `dut_done`=1 forced during LOAD is ignored.
- Memory holds 0x00..0x3F at READ_BASE=64 with READ_LEN=4. `dut_done` is raised 10 cycles into RUN → `out_valid` rises 2 cycles after `dut_done`. Output is 0x00,0x01,0x02,0x03. `out_ready` toggled 1/0 keeps the data stable while stalled.
- Wrap: LOAD_BASE=0xFE, LOAD_LEN=4 → writes to 0xFE, 0xFF, 0x00, 0x01.
- With `HOST_TIMEOUT_EN`, TIMEOUT=16 and `dut_done` never asserted → return to IDLE after 16 RUN cycles, with `timed_out`=1 and no `out_valid`. The next `start` clears `timed_out`.
- `reset` asserted in the middle of READ → the next edge gives `out_valid`=0, `busy`=0, `dut_reset`=1. A following `start` runs a complete job correctly.
